// File: rtl/if_cfg_dispatch.sv
// Configuration delivery stage: accepts a connection request, picks the endpoint that
// takes the configuration (dst or src) and streams the words to it through one output register.
module if_cfg_dispatch #(
    parameter int WIDTH_DATA        = 32,
    parameter int WIDTH_LEN         = 8,
    parameter int WIDTH_PID         = 5,
    parameter int ID_OFFSET_CTRL    = 0,
    parameter int ID_OFFSET_BRAM    = 1,
    parameter int ID_OFFSET_IFLOGIC = 9,
    parameter int ID_OFFSET_IFEXTRN = 13,
    parameter int NUM_UNITS         = 17
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Req,
    output logic                  O_Ack,
    input  logic [WIDTH_PID-1:0]  I_PDstID,
    input  logic [WIDTH_PID-1:0]  I_PSrcID,
    input  logic [WIDTH_LEN-1:0]  I_Len,
    input  logic                  I_Valid,
    output logic                  O_Ready,
    input  logic [WIDTH_DATA-1:0] I_Data,
    output logic                  O_Valid,
    input  logic                  I_Ready,
    output logic [WIDTH_DATA-1:0] O_Data,
    output logic [WIDTH_PID-1:0]  O_PUnitID,
    output logic                  O_SelDst,
    output logic                  O_Last,
    output logic                  O_Done,
    output logic                  O_Err
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                  stateReg, stateNext;
    logic [WIDTH_LEN-1:0]    lenReg;
    logic [WIDTH_LEN-1:0]    countReg;
    logic [WIDTH_DATA-1:0]   dataReg;
    logic [WIDTH_PID-1:0]    punitReg;
    logic                    validReg, lastReg, selReg, doneReg, errReg;

    int   dstIdx, srcIdx;
    logic dstInRange, srcInRange, reqInRange;
    logic srcBuf, srcIfl, srcExt, dstIfl, dstExt, reqSelDst;
    logic reqFire, lastLoaded, inFire, outFire, lastTaken;

    // Unit classes are contiguous ID ranges; only the classes the select rule needs are decoded.
    always_comb begin
        dstIdx     = int'(I_PDstID);
        srcIdx     = int'(I_PSrcID);
        dstInRange = (dstIdx >= ID_OFFSET_CTRL) && (dstIdx < NUM_UNITS);
        srcInRange = (srcIdx >= ID_OFFSET_CTRL) && (srcIdx < NUM_UNITS);
        reqInRange = dstInRange && srcInRange;
        srcBuf     = (srcIdx >= ID_OFFSET_BRAM) && (srcIdx < ID_OFFSET_IFLOGIC);
        srcIfl     = (srcIdx >= ID_OFFSET_IFLOGIC) && (srcIdx < ID_OFFSET_IFEXTRN);
        srcExt     = (srcIdx >= ID_OFFSET_IFEXTRN) && (srcIdx < NUM_UNITS);
        dstIfl     = (dstIdx >= ID_OFFSET_IFLOGIC) && (dstIdx < ID_OFFSET_IFEXTRN);
        dstExt     = (dstIdx >= ID_OFFSET_IFEXTRN) && (dstIdx < NUM_UNITS);
        reqSelDst  = srcBuf || (srcIfl && !dstIfl) || (srcExt && !dstExt);
    end

    // Input is refused once every word of the burst has been loaded.
    always_comb begin
        reqFire    = (stateReg == IDLE) && I_Req;
        lastLoaded = (countReg == lenReg);
        O_Ready    = (stateReg == SEND) && !lastLoaded && (!validReg || I_Ready);
        inFire     = I_Valid && O_Ready;
        outFire    = validReg && I_Ready;
        lastTaken  = outFire && lastReg;
    end

    always_comb begin
        stateNext = stateReg;
        O_Ack     = 1'b0;
        case (stateReg)
            IDLE: begin
                O_Ack = 1'b1;
                if (I_Req && reqInRange)
                    stateNext = (I_Len == '0) ? DONE : SEND;
            end
            SEND:    if (lastTaken) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg <= IDLE;
            lenReg   <= '0;
            countReg <= '0;
            dataReg  <= '0;
            punitReg <= '0;
            validReg <= 1'b0;
            lastReg  <= 1'b0;
            selReg   <= 1'b0;
            doneReg  <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            errReg   <= reqFire && !reqInRange;
            doneReg  <= (stateNext == DONE);
            if (reqFire && reqInRange) begin
                selReg   <= reqSelDst;
                punitReg <= reqSelDst ? I_PDstID : I_PSrcID;
                lenReg   <= I_Len;
                countReg <= '0;
            end
            if (inFire) begin
                dataReg  <= I_Data;
                validReg <= 1'b1;
                lastReg  <= (countReg == lenReg - WIDTH_LEN'(1));
                countReg <= countReg + WIDTH_LEN'(1);
            end else if (outFire) begin
                validReg <= 1'b0;
                lastReg  <= 1'b0;
            end
        end
    end

    assign O_Valid   = validReg;
    assign O_Data    = dataReg;
    assign O_Last    = lastReg;
    assign O_PUnitID = punitReg;
    assign O_SelDst  = selReg;
    assign O_Done    = doneReg;
    assign O_Err     = errReg;

endmodule

// File: tb/tb_if_cfg_dispatch.sv
// Bench for if_cfg_dispatch: directed request table, hand-written reset sequence,
// exhaustive select sweep and randomized bursts checked against a class-table scoreboard.
module tb_if_cfg_dispatch;

    localparam int WD = 32, WL = 8, WP = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          I_Req = 1'b0, I_Valid = 1'b0, I_Ready = 1'b0;
    logic [WP-1:0] I_PDstID = '0, I_PSrcID = '0;
    logic [WL-1:0] I_Len = '0;
    logic [WD-1:0] I_Data = '0;
    logic          O_Ack, O_Ready, O_Valid, O_SelDst, O_Last, O_Done, O_Err;
    logic [WD-1:0] O_Data;
    logic [WP-1:0] O_PUnitID;

    int    testsRun = 0;
    int    failCount = 0;
    string curTag = "";

    if_cfg_dispatch #(.WIDTH_DATA(WD), .WIDTH_LEN(WL), .WIDTH_PID(WP)) dut (
        .clock(clock), .reset(reset),
        .I_Req(I_Req), .O_Ack(O_Ack), .I_PDstID(I_PDstID), .I_PSrcID(I_PSrcID), .I_Len(I_Len),
        .I_Valid(I_Valid), .O_Ready(O_Ready), .I_Data(I_Data),
        .O_Valid(O_Valid), .I_Ready(I_Ready), .O_Data(O_Data), .O_PUnitID(O_PUnitID),
        .O_SelDst(O_SelDst), .O_Last(O_Last), .O_Done(O_Done), .O_Err(O_Err)
    );

    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s %s: got %0h expected %0h", curTag, name, act, exp);
        end
    endtask

    // Reference: class of an ID (0 FE, 1 BUF, 2 IFL, 3 EXT, 4 invalid) and a src x dst table.
    function automatic int classOf(input int id);
        if (id < 1)  return 0;
        if (id < 9)  return 1;
        if (id < 13) return 2;
        if (id < 17) return 3;
        return 4;
    endfunction

    function automatic logic modelSel(input int dst, input int src);
        logic [3:0] selRow [4];
        logic [3:0] row;
        selRow = '{4'b0000, 4'b1111, 4'b1011, 4'b0111};
        row = selRow[classOf(src)];
        return row[classOf(dst)];
    endfunction

    // rMode: 0 ready always, 1 random ready, 2 ready low on cycles 3 and 4.
    // vMode: 0 input valid always, 1 random input valid.
    task automatic runBurst(input int dst, input int src, input int len, input int rMode,
                            input int vMode, input logic expSel, input int expPunit,
                            input logic expErr);
        logic [WD-1:0] q[$];
        logic [WD-1:0] word, expWord, prevData;
        logic          prevLast, stallPrev;
        int            sent, recv, cyc, doneCyc, errCyc, doneCnt, errCnt;
        sent = 0; recv = 0; cyc = 0; doneCyc = -1; errCyc = -1; doneCnt = 0; errCnt = 0;
        stallPrev = 1'b0; prevData = '0; prevLast = 1'b0;
        word = $urandom;
        @(posedge clock); #1;
        I_Req = 1'b1; I_PDstID = WP'(dst); I_PSrcID = WP'(src); I_Len = WL'(len);
        I_Valid = 1'b0; I_Ready = 1'b1;
        @(negedge clock);
        chk("ack", O_Ack, 1);
        while (cyc < 400 && doneCyc < 0 && !(errCyc >= 0 && cyc >= errCyc + 3)) begin
            @(posedge clock); #1;
            I_Req = 1'b0;
            cyc++;
            if (sent < len) begin
                I_Valid = (vMode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                I_Data  = word;
            end else begin
                I_Valid = 1'(($urandom_range(0, 1)));
                I_Data  = 32'hDEAD0000 | WD'(cyc);
            end
            case (rMode)
                0:       I_Ready = 1'b1;
                1:       I_Ready = ($urandom_range(0, 2) != 0);
                default: I_Ready = !(cyc == 3 || cyc == 4);
            endcase
            @(negedge clock);
            if (stallPrev) begin
                chk("hold-valid", O_Valid, 1);
                chk("hold-data", O_Data, prevData);
                chk("hold-last", O_Last, prevLast);
            end
            if (O_Valid && !I_Ready) chk("stall-ready", O_Ready, 0);
            if (sent >= len) chk("no-extra-input", O_Ready, 0);
            if (I_Valid && O_Ready) begin
                q.push_back(I_Data);
                sent++;
                word = $urandom;
            end
            if (O_Valid && I_Ready) begin
                expWord = (q.size() > 0) ? q.pop_front() : 32'hBAD0BAD0;
                chk("data", O_Data, expWord);
                chk("last", O_Last, 64'(recv == len - 1));
                chk("punit-burst", O_PUnitID, expPunit);
                chk("sel-burst", O_SelDst, expSel);
                recv++;
            end
            if (O_Done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
                chk("sel", O_SelDst, expSel);
                chk("punit", O_PUnitID, expPunit);
                chk("valid-at-done", O_Valid, 0);
            end
            if (O_Err) begin
                errCnt++;
                if (errCyc < 0) errCyc = cyc;
            end
            stallPrev = O_Valid && !I_Ready;
            prevData  = O_Data;
            prevLast  = O_Last;
        end
        if (expErr) begin
            chk("err-cycle", errCyc, 1);
            chk("err-pulses", errCnt, 1);
            chk("err-no-done", doneCnt, 0);
        end else begin
            chk("done-timeout", 64'(doneCyc >= 0), 1);
            chk("words-out", recv, len);
            chk("no-err", errCnt, 0);
            if (rMode == 0 && vMode == 0)
                chk("done-latency", doneCyc, (len == 0) ? 1 : len + 2);
        end
        I_Valid = 1'b0;
    endtask

    typedef struct {
        int   dst, src, len, rMode;
        logic sel;
        int   punit;
        logic err;
    } reqVec_t;

    reqVec_t vecs [8];
    logic [WD-1:0] rw [5];

    initial begin
        vecs[0] = '{0, 3, 4, 0, 1'b1, 0, 1'b0};    // src BUF -> dst, full rate
        vecs[1] = '{2, 0, 2, 0, 1'b0, 0, 1'b0};    // src FE -> src
        vecs[2] = '{10, 11, 3, 0, 1'b0, 11, 1'b0}; // IFL -> IFL keeps src
        vecs[3] = '{0, 11, 3, 2, 1'b1, 0, 1'b0};   // two-cycle target stall
        vecs[4] = '{5, 14, 0, 0, 1'b1, 5, 1'b0};   // zero-length request
        vecs[5] = '{20, 3, 2, 0, 1'b0, 0, 1'b1};   // out-of-range dst
        vecs[6] = '{9, 13, 6, 1, 1'b1, 9, 1'b0};   // EXT -> IFL, random ready
        vecs[7] = '{15, 16, 2, 0, 1'b0, 16, 1'b0}; // EXT -> EXT keeps src

        curTag = "reset";
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst-valid", O_Valid, 0);
        chk("rst-last", O_Last, 0);
        chk("rst-done", O_Done, 0);
        chk("rst-err", O_Err, 0);
        chk("rst-sel", O_SelDst, 0);
        chk("rst-data", O_Data, 0);
        chk("rst-punit", O_PUnitID, 0);
        chk("rst-ready", O_Ready, 0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            curTag = $sformatf("vec%0d", i);
            runBurst(vecs[i].dst, vecs[i].src, vecs[i].len, vecs[i].rMode, 0,
                     vecs[i].sel, vecs[i].punit, vecs[i].err);
        end

        // Reset while the second of five words sits in the output register.
        curTag = "midreset";
        for (int i = 0; i < 5; i++) rw[i] = $urandom;
        @(posedge clock); #1;
        I_Req = 1'b1; I_PDstID = 5'd0; I_PSrcID = 5'd3; I_Len = 8'd5;
        @(negedge clock);
        chk("ack", O_Ack, 1);
        begin
            int k, cyc;
            bit hit;
            k = 0; cyc = 0; hit = 0;
            while (!hit && cyc < 20) begin
                @(posedge clock); #1;
                I_Req = 1'b0; I_Ready = 1'b1; cyc++;
                I_Valid = (k < 5); I_Data = rw[(k < 5) ? k : 4];
                @(negedge clock);
                if (O_Valid && O_Data == rw[1]) hit = 1;
                else if (I_Valid && O_Ready) k++;
            end
            chk("word2-seen", 64'(hit), 1);
        end
        #1 reset = 1'b0;
        #1;
        chk("mr-valid", O_Valid, 0);
        chk("mr-last", O_Last, 0);
        chk("mr-done", O_Done, 0);
        chk("mr-sel", O_SelDst, 0);
        chk("mr-data", O_Data, 0);
        chk("mr-punit", O_PUnitID, 0);
        chk("mr-ack", O_Ack, 1);
        I_Valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("mr-no-done", O_Done, 0);
            chk("mr-no-valid", O_Valid, 0);
        end
        curTag = "after-reset";
        runBurst(1, 14, 3, 0, 0, 1'b1, 1, 1'b0);

        for (int d = 0; d < 17; d++) begin
            for (int s = 0; s < 17; s++) begin
                curTag = $sformatf("sweep d%0d s%0d", d, s);
                runBurst(d, s, 0, 0, 0, modelSel(d, s), modelSel(d, s) ? d : s, 1'b0);
            end
        end

        for (int t = 0; t < 40; t++) begin
            int d, s, l;
            logic e, sl;
            d  = $urandom_range(0, 19);
            s  = $urandom_range(0, 19);
            l  = $urandom_range(0, 12);
            e  = (classOf(d) == 4) || (classOf(s) == 4);
            sl = e ? 1'b0 : modelSel(d, s);
            curTag = $sformatf("rand%0d d%0d s%0d l%0d", t, d, s, l);
            runBurst(d, s, l, $urandom_range(0, 1), $urandom_range(0, 1), sl,
                     sl ? d : s, e);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
